// File: rtl/pool_draw_manager_pkg.sv
// Shared definitions for the draw-without-replacement pool manager.
package pool_draw_manager_pkg;

   localparam int unsigned DefaultDepth = 90;
   localparam int unsigned DefaultAw    = 7;
   localparam int unsigned DefaultDw    = 7;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      RD_SEL,
      RD_LAST,
      WR_SEL,
      DONE,
      RET_WR
   } PoolState_t;

endpackage

// File: rtl/pool_draw_manager.sv
// Pool of DEPTH values held in external RAM; a draw removes a slot by moving
// the last entry into it, a return appends a value at the end.
module pool_draw_manager
   import pool_draw_manager_pkg::*;
#(
   parameter int unsigned DEPTH = DefaultDepth,
   parameter int unsigned AW    = DefaultAw,
   parameter int unsigned DW    = DefaultDw
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          DrawReq,
   input  logic [AW-1:0] DrawIdx,
   input  logic          ReturnReq,
   input  logic [DW-1:0] ReturnValue,
   output logic          DrawDone,
   output logic [DW-1:0] DrawValue,
   output logic          Busy,
   output logic [AW:0]   Count,
   output logic          Empty,
   output logic          Full,
   output logic          Error,
   output logic [AW-1:0] MemAddr,
   output logic [DW-1:0] MemWData,
   output logic          MemWE,
   output logic          MemStrobe,
   input  logic [DW-1:0] MemRData
);

   localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);
   localparam logic [AW:0] OneCnt   = (AW+1)'(1);

   PoolState_t    state;
   logic [AW:0]   initIdx;
   logic [AW-1:0] selIdx;
   logic [DW-1:0] wDataReg;

   // The last entry's read data only arrives during WR_SEL, so it is written straight through.
   assign MemWData = (state == WR_SEL) ? MemRData : wDataReg;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= INIT;
         initIdx   <= '0;
         selIdx    <= '0;
         wDataReg  <= '0;
         Count     <= '0;
         Empty     <= 1'b1;
         Full      <= 1'b0;
         Busy      <= 1'b1;
         DrawDone  <= 1'b0;
         DrawValue <= '0;
         Error     <= 1'b0;
         MemAddr   <= '0;
         MemWE     <= 1'b0;
         MemStrobe <= 1'b0;
      end else begin
         DrawDone  <= 1'b0;
         Error     <= 1'b0;
         MemWE     <= 1'b0;
         MemStrobe <= 1'b0;
         case (state)
            INIT: begin
               if (initIdx == DepthCnt) begin
                  Count <= DepthCnt;
                  Empty <= 1'b0;
                  Full  <= 1'b1;
                  Busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  MemAddr   <= AW'(initIdx);
                  wDataReg  <= DW'(initIdx + OneCnt);
                  MemWE     <= 1'b1;
                  MemStrobe <= 1'b1;
                  initIdx   <= initIdx + OneCnt;
               end
            end
            IDLE: begin
               if (DrawReq) begin
                  if ({1'b0, DrawIdx} >= Count) begin
                     Error <= 1'b1;
                  end else begin
                     selIdx    <= DrawIdx;
                     MemAddr   <= DrawIdx;
                     MemStrobe <= 1'b1;
                     Busy      <= 1'b1;
                     state     <= RD_SEL;
                  end
               end else if (ReturnReq) begin
                  if (Full) begin
                     Error <= 1'b1;
                  end else begin
                     MemAddr   <= AW'(Count);
                     wDataReg  <= ReturnValue;
                     MemWE     <= 1'b1;
                     MemStrobe <= 1'b1;
                     Busy      <= 1'b1;
                     state     <= RET_WR;
                  end
               end
            end
            RD_SEL: begin
               MemAddr   <= AW'(Count - OneCnt);
               MemStrobe <= 1'b1;
               state     <= RD_LAST;
            end
            RD_LAST: begin
               DrawValue <= MemRData;
               MemAddr   <= selIdx;
               MemWE     <= 1'b1;
               MemStrobe <= 1'b1;
               state     <= WR_SEL;
            end
            WR_SEL: begin
               wDataReg <= MemRData;
               DrawDone <= 1'b1;
               Count    <= Count - OneCnt;
               Empty    <= (Count == OneCnt);
               Full     <= 1'b0;
               state    <= DONE;
            end
            DONE: begin
               Busy  <= 1'b0;
               state <= IDLE;
            end
            RET_WR: begin
               Count <= Count + OneCnt;
               Empty <= 1'b0;
               Full  <= ((Count + OneCnt) == DepthCnt);
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               initIdx <= '0;
               Busy    <= 1'b1;
               state   <= INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pool_draw_manager.sv
// Directed bench for pool_draw_manager with a behavioural RAM and a reference pool model.
module tb_pool_draw_manager;
   import pool_draw_manager_pkg::*;

   localparam int unsigned DEPTH = 90;
   localparam int unsigned AW    = 7;
   localparam int unsigned DW    = 7;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          DrawReq = 1'b0;
   logic [AW-1:0] DrawIdx = '0;
   logic          ReturnReq = 1'b0;
   logic [DW-1:0] ReturnValue = '0;
   logic          DrawDone;
   logic [DW-1:0] DrawValue;
   logic          Busy;
   logic [AW:0]   Count;
   logic          Empty;
   logic          Full;
   logic          Error;
   logic [AW-1:0] MemAddr;
   logic [DW-1:0] MemWData;
   logic          MemWE;
   logic          MemStrobe;
   logic [DW-1:0] MemRData;

   always #5 Clk = ~Clk;

   pool_draw_manager #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .Clk(Clk), .Reset(Reset),
      .DrawReq(DrawReq), .DrawIdx(DrawIdx),
      .ReturnReq(ReturnReq), .ReturnValue(ReturnValue),
      .DrawDone(DrawDone), .DrawValue(DrawValue), .Busy(Busy),
      .Count(Count), .Empty(Empty), .Full(Full), .Error(Error),
      .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE),
      .MemStrobe(MemStrobe), .MemRData(MemRData)
   );

   // External single-port RAM, read data one cycle after the strobe
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge Clk) begin
      if (MemStrobe) begin
         if (MemWE) ram[MemAddr] <= MemWData;
         else       MemRData <= ram[MemAddr];
      end
   end

   int writeCnt = 0;
   int doneCnt = 0;
   always @(posedge Clk) begin
      if (MemStrobe && MemWE) writeCnt++;
      if (DrawDone) doneCnt++;
   end

   int nCompared = 0;
   int nMismatch = 0;
   logic [DW-1:0] refMem [0:DEPTH-1];
   int refCount = 0;
   logic [DW-1:0] expQ [$];
   logic [DW-1:0] lastDrawn = '0;
   int seen [0:DEPTH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatch++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge Clk);
   endtask

   task automatic checkMem(input string tag);
      int bad = 0;
      for (int i = 0; i < int'(DEPTH); i++) if (ram[i] !== refMem[i]) bad++;
      check(tag, 32'(bad), 32'd0);
   endtask

   task automatic doReset();
      int base;
      Reset = 1'b1;
      base = writeCnt;
      repeat (3) tick();
      check("rst_busy", 32'(Busy), 32'd1);
      check("rst_count", 32'(Count), 32'd0);
      check("rst_drawdone", 32'(DrawDone), 32'd0);
      check("rst_error", 32'(Error), 32'd0);
      check("rst_strobe", 32'({MemStrobe, MemWE}), 32'd0);
      check("rst_addr_wdata", 32'({MemAddr, MemWData}), 32'd0);
      check("rst_drawvalue", 32'(DrawValue), 32'd0);
      check("rst_no_writes", 32'(writeCnt - base), 32'd0);
      Reset = 1'b0;
   endtask

   task automatic waitInit();
      int n = 0;
      int base = writeCnt;
      while (Busy !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      check("init_done_in_time", 32'(n < 300), 32'd1);
      check("init_writes", 32'(writeCnt - base), 32'(DEPTH));
      check("init_count", 32'(Count), 32'(DEPTH));
      check("init_full_empty", 32'({Full, Empty}), 32'b10);
      check("idle_strobe", 32'({MemStrobe, MemWE}), 32'd0);
      for (int i = 0; i < int'(DEPTH); i++) refMem[i] = DW'(i + 1);
      refCount = int'(DEPTH);
      checkMem("init_mem");
   endtask

   task automatic doDraw(input int idx, input bit withRet, input logic [DW-1:0] retVal);
      bit accept;
      int lat;
      logic [DW-1:0] expVal;
      accept = (idx < refCount);
      DrawReq = 1'b1;
      DrawIdx = AW'(idx);
      ReturnReq = withRet;
      ReturnValue = retVal;
      if (accept) begin
         expQ.push_back(refMem[idx]);
         refMem[idx] = refMem[refCount-1];
         refCount--;
      end
      tick();
      DrawReq = 1'b0;
      ReturnReq = 1'b0;
      if (!accept) begin
         check("draw_reject_error", 32'(Error), 32'd1);
         check("draw_reject_busy", 32'(Busy), 32'd0);
         check("draw_reject_count", 32'(Count), 32'(refCount));
         check("draw_value_held", 32'(DrawValue), 32'(lastDrawn));
         return;
      end
      check("draw_busy", 32'(Busy), 32'd1);
      lat = 1;
      while (DrawDone !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      check("draw_latency", 32'(lat), 32'd4);
      check("draw_busy_at_done", 32'(Busy), 32'd1);
      expVal = (expQ.size() > 0) ? expQ.pop_front() : 'x;
      check("draw_value", 32'(DrawValue), 32'(expVal));
      check("draw_count", 32'(Count), 32'(refCount));
      lastDrawn = DrawValue;
      tick();
      check("draw_idle", 32'({Busy, DrawDone}), 32'd0);
   endtask

   task automatic doReturn(input logic [DW-1:0] val);
      bit accept;
      int base;
      accept = (refCount < int'(DEPTH));
      base = writeCnt;
      ReturnReq = 1'b1;
      ReturnValue = val;
      tick();
      ReturnReq = 1'b0;
      if (!accept) begin
         check("ret_reject_error", 32'(Error), 32'd1);
         tick();
         check("ret_reject_nowrite", 32'(writeCnt - base), 32'd0);
         check("ret_reject_count", 32'(Count), 32'(refCount));
         return;
      end
      check("ret_busy_we", 32'({Busy, MemWE}), 32'b11);
      refMem[refCount] = val;
      refCount++;
      tick();
      check("ret_idle", 32'(Busy), 32'd0);
      check("ret_count", 32'(Count), 32'(refCount));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int base;
      tick();
      doReset();
      waitInit();

      // Draw from the middle: last entry moves into slot 5
      doDraw(5, 1'b0, '0);
      check("mem5_after_draw", 32'(ram[5]), 32'd90);
      checkMem("mem_after_draw5");

      // Draw and return together: draw of the last slot wins
      doDraw(88, 1'b1, DW'(33));
      checkMem("mem_after_draw88");
      doReturn(DW'(6));
      check("mem88_after_return", 32'(ram[88]), 32'd6);
      checkMem("mem_after_return");

      // Out-of-range draw, fill to Full, return while Full
      doDraw(refCount, 1'b0, '0);
      doReturn(DW'(89));
      check("full_flag", 32'(Full), 32'd1);
      doReturn(DW'(7));
      checkMem("mem_after_full_reject");

      // Drain to Empty: every value 1..90 exactly once
      for (int v = 0; v <= int'(DEPTH); v++) seen[v] = 0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         doDraw(int'($urandom_range(refCount - 1, 0)), 1'b0, '0);
         if (int'(lastDrawn) <= int'(DEPTH)) seen[lastDrawn]++;
      end
      bad = 0;
      for (int v = 1; v <= int'(DEPTH); v++) if (seen[v] != 1) bad++;
      check("drain_unique_values", 32'(bad), 32'd0);
      check("drain_empty", 32'({Empty, Full}), 32'b10);
      doDraw(0, 1'b0, '0);

      // Reset landing in RD_LAST abandons the draw
      doReset();
      waitInit();
      base = doneCnt;
      DrawReq = 1'b1;
      DrawIdx = AW'(3);
      tick();
      DrawReq = 1'b0;
      check("abort_busy", 32'(Busy), 32'd1);
      tick();
      Reset = 1'b1;
      tick();
      tick();
      check("abort_in_init", 32'({Busy, Count}), 32'({1'b1, (AW+1)'(0)}));
      Reset = 1'b0;
      waitInit();
      check("abort_no_drawdone", 32'(doneCnt - base), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
